// File: rtl/framer_if.sv
// Byte-stream handshake bundle (AXI4-Stream subset) shared by framer ports.
interface framer_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/framer.sv
// Frame encoder: wraps each AXI4-Stream packet as START, escaped payload, STOP.
module framer #(
    parameter logic [7:0] ESCAPE_BYTE = 8'h7F,
    parameter logic [7:0] START_BYTE  = 8'h7D,
    parameter logic [7:0] STOP_BYTE   = 8'h7E
) (
    input  logic      aclk,
    input  logic      aresetn,
    framer_if.slave   target,
    framer_if.master  initiator
);

    localparam int unsigned DATA_W = 8;

    // Control bytes must be distinguishable on the wire.
    if ((ESCAPE_BYTE == START_BYTE) || (ESCAPE_BYTE == STOP_BYTE) || (START_BYTE == STOP_BYTE)) begin : g_param_check
        $error("framer: ESCAPE_BYTE, START_BYTE and STOP_BYTE must be distinct");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ESC,
        ST_STOP
    } state_t;

    state_t              r_state;
    logic                r_tvalid;
    logic [DATA_W-1:0]   r_tdata;
    logic [DATA_W-1:0]   r_hold_data;
    logic                r_hold_last;

    logic                w_slot_free;
    logic                w_special;
    logic                w_handshake;

    // Output slot can take a new byte when empty or being drained this cycle.
    assign w_slot_free = !r_tvalid || initiator.tready;
    assign w_special   = (target.tdata == ESCAPE_BYTE) ||
                         (target.tdata == START_BYTE)  ||
                         (target.tdata == STOP_BYTE);
    assign target.tready = w_slot_free && (r_state == ST_DATA);
    assign w_handshake   = target.tvalid && w_slot_free && (r_state == ST_DATA);

    assign initiator.tvalid = r_tvalid;
    assign initiator.tdata  = r_tdata;
    assign initiator.tlast  = 1'b0;

    // Frame sequencer and output register; a loaded byte overrides the default drain.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_tvalid    <= 1'b0;
            r_tdata     <= DATA_W'(0);
            r_hold_data <= DATA_W'(0);
            r_hold_last <= 1'b0;
        end else begin
            if (w_slot_free) begin
                r_tvalid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    // Payload byte stays pending; only the marker goes out.
                    if (w_slot_free && target.tvalid) begin
                        r_tvalid <= 1'b1;
                        r_tdata  <= START_BYTE;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_handshake) begin
                        r_tvalid <= 1'b1;
                        if (w_special) begin
                            r_tdata     <= ESCAPE_BYTE;
                            r_hold_data <= target.tdata;
                            r_hold_last <= target.tlast;
                            r_state     <= ST_ESC;
                        end else begin
                            r_tdata <= target.tdata;
                            if (target.tlast) begin
                                r_state <= ST_STOP;
                            end
                        end
                    end
                end
                ST_ESC: begin
                    if (w_slot_free) begin
                        r_tvalid <= 1'b1;
                        r_tdata  <= r_hold_data;
                        r_state  <= r_hold_last ? ST_STOP : ST_DATA;
                    end
                end
                ST_STOP: begin
                    if (w_slot_free) begin
                        r_tvalid <= 1'b1;
                        r_tdata  <= STOP_BYTE;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_framer.sv
// Self-checking bench for framer: cycle table, directed frames, random frames with backpressure.
module tb_framer;

    logic clk;
    logic rst_n;

    framer_if tgt ();
    framer_if ini ();

    framer dut (
        .aclk      (clk),
        .aresetn   (rst_n),
        .target    (tgt.slave),
        .initiator (ini.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] src_data[$];
    bit         src_last[$];
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    bit         in_frame = 1'b0;

    typedef struct {
        logic       tv;
        logic [7:0] td;
        logic       tl;
        logic       rdy;
        logic       e_tready;
        logic       e_ov;
        logic [7:0] e_od;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_ctrl(input logic [7:0] b);
        return (b == 8'h7F) || (b == 8'h7D) || (b == 8'h7E);
    endfunction

    // Reference model: append one payload byte and the wire bytes it should produce.
    task automatic add_byte(input logic [7:0] b, input bit last);
        src_data.push_back(b);
        src_last.push_back(last);
        if (!in_frame) begin
            exp_q.push_back(8'h7D);
            in_frame = 1'b1;
        end
        if (is_ctrl(b)) exp_q.push_back(8'h7F);
        exp_q.push_back(b);
        if (last) begin
            exp_q.push_back(8'h7E);
            in_frame = 1'b0;
        end
    endtask

    // Drives queued payload, collects output bytes, checks hold-under-stall and final sequence.
    task automatic run_stream(input string tag, input bit rand_ready, input bit rand_gap,
                              input int budget, output int span);
        int         idx;
        int         cyc;
        int         first;
        int         last_c;
        bit         cur_v;
        bit         prev_stall;
        bit         hs_in;
        logic [7:0] prev_d;
        idx = 0; cyc = 0; first = -1; last_c = -1;
        cur_v = 1'b0; prev_stall = 1'b0; prev_d = 8'h00;
        got.delete();
        while ((idx < src_data.size() || got.size() < exp_q.size()) && cyc < budget) begin
            @(negedge clk);
            if (!cur_v && idx < src_data.size())
                cur_v = rand_gap ? ($urandom_range(0, 99) < 70) : 1'b1;
            tgt.tvalid = cur_v;
            tgt.tdata  = cur_v ? src_data[idx] : 8'($urandom);
            tgt.tlast  = cur_v ? src_last[idx] : 1'($urandom);
            ini.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall) begin
                check({tag, "_hold_valid"}, 32'(ini.tvalid), 32'd1);
                check({tag, "_hold_data"}, 32'(ini.tdata), 32'(prev_d));
            end
            prev_stall = ini.tvalid && !ini.tready;
            prev_d     = ini.tdata;
            if (ini.tvalid && ini.tready) begin
                got.push_back(ini.tdata);
                if (first < 0) first = cyc;
                last_c = cyc;
            end
            hs_in = tgt.tvalid && tgt.tready;
            @(posedge clk);
            if (hs_in) begin
                idx++;
                cur_v = 1'b0;
            end
            cyc++;
        end
        check({tag, "_in_budget"}, 32'(cyc < budget), 32'd1);
        // Idle tail: nothing more may come out.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tgt.tvalid = 1'b0;
            ini.tready = 1'b1;
            #1;
            if (ini.tvalid) got.push_back(ini.tdata);
        end
        check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check({tag, "_byte"}, 32'(got[i]), 32'(exp_q[i]));
        span = last_c - first + 1;
        src_data.delete();
        src_last.delete();
        exp_q.delete();
    endtask

    initial begin
        int span;
        rst_n      = 1'b0;
        tgt.tvalid = 1'b0;
        tgt.tdata  = 8'h00;
        tgt.tlast  = 1'b0;
        ini.tready = 1'b0;

        // Basic frame 01 02 03 cycle by cycle with tready high.
        vecs[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h7D};
        vecs[2] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01};
        vecs[3] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02};
        vecs[4] = '{1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03};
        vecs[5] = '{1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 8'h7E};
        vecs[6] = '{1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

        repeat (3) @(negedge clk);
        #1;
        check("rst_tvalid", 32'(ini.tvalid), 32'd0);
        check("rst_tdata",  32'(ini.tdata),  32'h00);
        check("rst_tready", 32'(tgt.tready), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            tgt.tvalid = vecs[i].tv;
            tgt.tdata  = vecs[i].td;
            tgt.tlast  = vecs[i].tl;
            ini.tready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_tready", i), 32'(tgt.tready), 32'(vecs[i].e_tready));
            check($sformatf("vec%0d_ovalid", i), 32'(ini.tvalid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov)
                check($sformatf("vec%0d_odata", i), 32'(ini.tdata), 32'(vecs[i].e_od));
        end

        // Escaping of all three control values.
        add_byte(8'h7F, 1'b0);
        add_byte(8'h7D, 1'b0);
        add_byte(8'h7E, 1'b1);
        run_stream("esc", 1'b0, 1'b0, 100, span);
        check("esc_span", 32'(span), 32'd8);

        // Single control byte: ESC then STOP via hold_last.
        add_byte(8'h7E, 1'b1);
        run_stream("single", 1'b0, 1'b0, 100, span);
        check("single_span", 32'(span), 32'd4);

        // Back-to-back frames with no bubble between STOP and START.
        add_byte(8'hAA, 1'b1);
        add_byte(8'hBB, 1'b1);
        run_stream("b2b", 1'b0, 1'b0, 100, span);
        check("b2b_span", 32'(span), 32'd6);

        // Reset mid-frame after 7D 11 has been emitted.
        @(negedge clk);
        tgt.tvalid = 1'b1; tgt.tdata = 8'h11; tgt.tlast = 1'b0; ini.tready = 1'b1;
        #1;
        check("mid_idle_tready", 32'(tgt.tready), 32'd0);
        @(negedge clk);
        #1;
        check("mid_start", 32'(ini.tdata), 32'h7D);
        check("mid_data_tready", 32'(tgt.tready), 32'd1);
        @(negedge clk);
        tgt.tdata = 8'h12;
        #1;
        check("mid_byte_valid", 32'(ini.tvalid), 32'd1);
        check("mid_byte", 32'(ini.tdata), 32'h11);
        @(negedge clk);
        rst_n = 1'b0;
        tgt.tvalid = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(ini.tvalid), 32'd0);
        check("mid_rst_tready", 32'(tgt.tready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        add_byte(8'h22, 1'b1);
        run_stream("after_rst", 1'b0, 1'b0, 100, span);
        check("after_rst_span", 32'(span), 32'd3);

        // Random frames, random source gaps, 50% downstream backpressure.
        for (int f = 0; f < 20; f++) begin
            int len;
            len = $urandom_range(1, 64);
            for (int j = 0; j < len; j++) begin
                logic [7:0] b;
                case ($urandom_range(0, 7))
                    0: b = 8'h7D;
                    1: b = 8'h7E;
                    2: b = 8'h7F;
                    default: b = 8'($urandom);
                endcase
                add_byte(b, j == len - 1);
            end
        end
        run_stream("rand", 1'b1, 1'b1, 20000, span);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
